// File: rtl/pedidos_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pedidos_pkg
//  Description : Shared encodings for the order front-end of maquina_maluca:
//                machine state codes, controller FSM codes and the
//                watchdog width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package pedidos_pkg;

    // maquina_maluca state codes. Codes 2..8 are intermediate brew steps
    // that the controller never interprets, only IDLE matters to it.
    localparam logic [3:0] MM_IDLE              = 4'd1;
    localparam logic [3:0] MM_REALIZAR_EXTRACAO = 4'd9;

    // Controller FSM encoding
    typedef logic [1:0] estado_t;
    localparam logic [1:0] ESPERA      = 2'd0;
    localparam logic [1:0] DISPARA     = 2'd1;
    localparam logic [1:0] AGUARDA_FIM = 2'd2;
    localparam logic [1:0] FALHA       = 2'd3;

    // Watchdog must be able to hold values up to and including the timeout
    function automatic int largura_watchdog(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/detector_borda.sv
`default_nettype none
// ============================================================================
//  Module      : detector_borda
//  Description : Rising-edge detector. The previous level is registered so a
//                held input produces a single pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module detector_borda (
    input  logic clk,
    input  logic rst_n,
    input  logic sinal,
    output logic borda
);

    logic r_anterior;

    // Remember last cycle's level of the input
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_anterior <= 1'b0;
        end else begin
            r_anterior <= sinal;
        end
    end

    assign borda = sinal & ~r_anterior;

endmodule
`default_nettype wire

// File: rtl/controlador_pedidos.sv
`default_nettype none
// ============================================================================
//  Module      : controlador_pedidos
//  Description : Order front-end for maquina_maluca. Buffers button presses,
//                drives the start handshake, counts finished cups and trips
//                a watchdog when the machine stalls.
//  Revision    : 1.0 - initial release
// ============================================================================
module controlador_pedidos
    import pedidos_pkg::*;
#(
    parameter int         MAX_PEDIDOS = 4,
    parameter int         TIMEOUT     = 32,
    parameter logic [3:0] IDLE_CODE   = MM_IDLE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pedido,
    input  logic        limpar_erro,
    input  logic [3:0]  state_in,
    output logic        start,
    output logic [3:0]  pendentes,
    output logic        ocupado,
    output logic        cafe_pronto,
    output logic [15:0] xicaras,
    output logic        overflow,
    output logic        erro
);

    localparam int              WD_W        = largura_watchdog(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LIMITE   = WD_W'(TIMEOUT - 1);
    localparam logic [3:0]      LIMITE_PEND = 4'(MAX_PEDIDOS);

    estado_t         r_estado;
    estado_t         w_prox;
    logic [WD_W-1:0] r_wd;
    logic            w_novo;
    logic            w_consumo;
    logic            w_fim;
    logic            w_wd_esgotado;
    logic            w_aceita;
    logic [3:0]      w_liquido;

    detector_borda u_detector_borda (
        .clk   (clk),
        .rst_n (rst_n),
        .sinal (pedido),
        .borda (w_novo)
    );

    // The watchdog value at its last allowed count means this cycle is the
    // TIMEOUT-th one spent in the current waiting state.
    assign w_wd_esgotado = (r_wd == WD_LIMITE);

    // Room is judged after this cycle's consumption, so an order arriving
    // exactly when one is taken at full is still accepted.
    assign w_liquido = pendentes - {3'b000, w_consumo};
    assign w_aceita  = w_novo && (w_liquido < LIMITE_PEND);

    // Next-state logic with the consume and brew-finished strobes
    always_comb begin
        w_prox    = r_estado;
        w_consumo = 1'b0;
        w_fim     = 1'b0;
        case (r_estado)
            ESPERA: begin
                if ((pendentes != 4'd0) && (state_in == IDLE_CODE)) begin
                    w_prox = DISPARA;
                end
            end
            DISPARA: begin
                if (state_in != IDLE_CODE) begin
                    w_prox    = AGUARDA_FIM;
                    w_consumo = (pendentes != 4'd0);
                end else if (w_wd_esgotado) begin
                    // Order stays buffered; machine never acknowledged it
                    w_prox = FALHA;
                end
            end
            AGUARDA_FIM: begin
                if (state_in == IDLE_CODE) begin
                    w_prox = ESPERA;
                    w_fim  = 1'b1;
                end else if (w_wd_esgotado) begin
                    w_prox = FALHA;
                end
            end
            FALHA: begin
                if (limpar_erro) begin
                    w_prox = ESPERA;
                end
            end
            default: begin
                w_prox = ESPERA;
            end
        endcase
    end

    // State register with status outputs decoded from the next state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_estado <= ESPERA;
            start    <= 1'b0;
            ocupado  <= 1'b0;
            erro     <= 1'b0;
        end else begin
            r_estado <= w_prox;
            start    <= (w_prox == DISPARA);
            ocupado  <= (w_prox == DISPARA) || (w_prox == AGUARDA_FIM);
            erro     <= (w_prox == FALHA);
        end
    end

    // Watchdog: restarts on each transition, counts only while waiting on the machine
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wd <= '0;
        end else if (w_prox != r_estado) begin
            r_wd <= '0;
        end else if ((r_estado == DISPARA) || (r_estado == AGUARDA_FIM)) begin
            r_wd <= r_wd + WD_W'(1);
        end else begin
            r_wd <= '0;
        end
    end

    // Pending-order buffer and dropped-order pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pendentes <= 4'd0;
            overflow  <= 1'b0;
        end else begin
            pendentes <= pendentes + {3'b000, w_aceita} - {3'b000, w_consumo};
            overflow  <= w_novo && !w_aceita;
        end
    end

    // Finished-cup pulse and wrapping cup counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cafe_pronto <= 1'b0;
            xicaras     <= 16'd0;
        end else begin
            cafe_pronto <= w_fim;
            if (w_fim) begin
                xicaras <= xicaras + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_controlador_pedidos.sv
`default_nettype none
// ============================================================================
//  Module      : tb_controlador_pedidos
//  Description : Directed self-checking bench for controlador_pedidos with a
//                small behavioural stand-in for maquina_maluca.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_controlador_pedidos;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pedido = 1'b0;
    logic        limpar_erro = 1'b0;
    logic [3:0]  state_in;
    logic        start;
    logic [3:0]  pendentes;
    logic        ocupado;
    logic        cafe_pronto;
    logic [15:0] xicaras;
    logic        overflow;
    logic        erro;

    int checks = 0;
    int errors = 0;

    controlador_pedidos #(
        .MAX_PEDIDOS (4),
        .TIMEOUT     (32),
        .IDLE_CODE   (4'd1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pedido      (pedido),
        .limpar_erro (limpar_erro),
        .state_in    (state_in),
        .start       (start),
        .pendentes   (pendentes),
        .ocupado     (ocupado),
        .cafe_pronto (cafe_pronto),
        .xicaras     (xicaras),
        .overflow    (overflow),
        .erro        (erro)
    );

    always #5 clk = ~clk;

    // Machine stand-in: IDLE, on start run 2,3,4,3,5,6,7,8,9 then back to IDLE.
    logic stuck = 1'b0;
    logic m_rodando;
    int   m_idx;

    function automatic logic [3:0] seq_mm(input int i);
        case (i)
            0: return 4'd2;
            1: return 4'd3;
            2: return 4'd4;
            3: return 4'd3;
            4: return 4'd5;
            5: return 4'd6;
            6: return 4'd7;
            7: return 4'd8;
            8: return 4'd9;
            default: return 4'd1;
        endcase
    endfunction

    always @(posedge clk) begin
        if (!rst_n || stuck) begin
            state_in  <= 4'd1;
            m_rodando <= 1'b0;
            m_idx     <= 0;
        end else if (m_rodando) begin
            state_in <= seq_mm(m_idx);
            if (m_idx == 9) m_rodando <= 1'b0;
            else            m_idx <= m_idx + 1;
        end else if (state_in == 4'd1 && start) begin
            state_in  <= seq_mm(0);
            m_idx     <= 1;
            m_rodando <= 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulso();
        pedido = 1'b1;
        tick();
        pedido = 1'b0;
        tick();
    endtask

    task automatic drenar(input string tag);
        int n;
        n = 0;
        while (!(pendentes === 4'd0 && ocupado === 1'b0 && state_in === 4'd1 && start === 1'b0)
               && n < 300) begin
            tick();
            n++;
        end
        chk(tag, (n < 300), 1);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_start"},     start,       0);
        chk({tag, "_pend"},      pendentes,   0);
        chk({tag, "_ocupado"},   ocupado,     0);
        chk({tag, "_cafe"},      cafe_pronto, 0);
        chk({tag, "_xicaras"},   xicaras,     0);
        chk({tag, "_overflow"},  overflow,    0);
        chk({tag, "_erro"},      erro,        0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1);
    end

    initial begin
        logic [3:0] exp_seq [10];
        logic [3:0] rec [16];
        logic [3:0] prev;
        int n_rec, n_start, n_cafe, n_ovf, n;
        logic [15:0] x0;

        exp_seq = '{4'd2, 4'd3, 4'd4, 4'd3, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd1};

        // ---------------- reset ----------------
        rst_n = 1'b0;
        tick();
        tick();
        chk_reset("rst");
        rst_n = 1'b1;
        tick();

        // ---------------- single order ----------------
        pedido = 1'b1;
        tick();
        pedido = 1'b0;
        chk("single_pend_accept", pendentes, 1);
        n_rec = 0; n_start = 0; n_cafe = 0; prev = 4'd1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (start === 1'b1) n_start++;
            if (cafe_pronto === 1'b1) n_cafe++;
            if (state_in !== prev && n_rec < 16) begin
                rec[n_rec] = state_in;
                n_rec++;
            end
            prev = state_in;
        end
        chk("single_start_cycles", n_start, 2);
        chk("single_cafe_pulses", n_cafe, 1);
        chk("single_xicaras", xicaras, 1);
        chk("single_pend_end", pendentes, 0);
        chk("single_seq_len", n_rec, 10);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("single_seq_%0d", i), rec[i], exp_seq[i]);
        end

        // ---------------- burst while busy ----------------
        x0 = xicaras;
        pedido = 1'b1;
        tick();
        pedido = 1'b0;
        n = 0;
        while (!(ocupado === 1'b1 && start === 1'b0) && n < 20) begin
            tick();
            n++;
        end
        chk("burst_busy_reached", (n < 20), 1);
        n_ovf = 0;
        for (int i = 0; i < 6; i++) begin
            pedido = 1'b1;
            tick();
            if (overflow === 1'b1) n_ovf++;
            chk($sformatf("burst_ovf_%0d", i), overflow, (i >= 4) ? 1 : 0);
            chk($sformatf("burst_pend_%0d", i), pendentes, (i >= 3) ? 4 : i + 1);
            pedido = 1'b0;
            tick();
            if (overflow === 1'b1) n_ovf++;
        end
        chk("burst_ovf_count", n_ovf, 2);
        drenar("burst_drain");
        chk("burst_xicaras", xicaras - x0, 5);

        // ---------------- held button ----------------
        x0 = xicaras;
        pedido = 1'b1;
        tick();
        chk("held_pend_first", pendentes, 1);
        repeat (19) tick();
        pedido = 1'b0;
        repeat (30) tick();
        chk("held_xicaras", xicaras - x0, 1);
        chk("held_pend_end", pendentes, 0);

        // ---------------- simultaneous accept/consume at full ----------------
        x0 = xicaras;
        stuck = 1'b1;
        repeat (4) pulso();
        chk("full_pend", pendentes, 4);
        chk("full_start", start, 1);
        stuck = 1'b0;
        tick();
        chk("full_machine_started", state_in, 2);
        pedido = 1'b1;
        tick();
        pedido = 1'b0;
        chk("full_pend_same", pendentes, 4);
        chk("full_no_overflow", overflow, 0);
        chk("full_start_drop", start, 0);
        tick();
        chk("full_no_overflow_late", overflow, 0);
        drenar("full_drain");
        chk("full_xicaras", xicaras - x0, 5);

        // ---------------- stuck machine ----------------
        stuck = 1'b1;
        pedido = 1'b1;
        tick();
        pedido = 1'b0;
        chk("stuck_pend", pendentes, 1);
        tick();
        chk("stuck_start", start, 1);
        repeat (31) tick();
        chk("stuck_erro_before", erro, 0);
        chk("stuck_start_before", start, 1);
        tick();
        chk("stuck_erro", erro, 1);
        chk("stuck_start_low", start, 0);
        chk("stuck_pend_kept", pendentes, 1);
        chk("stuck_ocupado", ocupado, 0);
        limpar_erro = 1'b1;
        tick();
        limpar_erro = 1'b0;
        chk("clear_erro", erro, 0);
        chk("clear_start", start, 0);
        tick();
        chk("clear_restart", start, 1);
        stuck = 1'b0;
        drenar("stuck_drain");
        chk("stuck_pend_end", pendentes, 0);

        // ---------------- reset mid-brew ----------------
        pedido = 1'b1;
        tick();
        pedido = 1'b0;
        n = 0;
        while (!(ocupado === 1'b1 && start === 1'b0) && n < 20) begin
            tick();
            n++;
        end
        chk("midrst_busy_reached", (n < 20), 1);
        pedido = 1'b1;
        tick();
        pedido = 1'b0;
        chk("midrst_pend", pendentes, 1);
        rst_n = 1'b0;
        tick();
        chk_reset("midrst");
        rst_n = 1'b1;
        tick();
        chk("midrst_idle_machine", state_in, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
